// File: rtl/aq_cjpeg_bitpack.sv
// rtl/aq_cjpeg_bitpack.sv - JPEG entropy-coded segment bit packer with 0xFF stuffing, 1-padding and RST/EOI markers
// Optional feature macro: AQ_CJPEG_RESTART_EN (RSTn marker insertion; otherwise Restart behaves as Align)
module aq_cjpeg_bitpack (
  input  logic        clk,
  input  logic        rst,
  input  logic        ProcessInit,
  input  logic        DataInEnable,
  input  logic [5:0]  DataInWidth,
  input  logic [31:0] DataIn,
  input  logic        DataInAlign,
  input  logic        DataInRestart,
  input  logic        DataInFinish,
  output logic        DataInReady,
  output logic        DataOutEnable,
  input  logic        DataOutRead,
  output logic [7:0]  DataOut,
  output logic        Idle
);

  typedef enum logic [1:0] {S_DATA, S_FLUSH, S_MARK_FF, S_MARK_CODE} state_t;

  state_t      r_state;
  logic [63:0] r_buf;
  logic [6:0]  r_cnt;
  logic        r_stuff;
  logic [7:0]  r_dout;
  logic        r_dout_en;
`ifdef AQ_CJPEG_RESTART_EN
  logic        r_eoi;
  logic [2:0]  r_rst_idx;
`endif

  logic        w_ready, w_slot, w_drain_ok, w_emit_stuff, w_emit_data;
  logic        w_accept, w_cmd, w_emit;
  logic [63:0] w_buf_d, w_buf_a, w_buf_p, w_field_la;
  logic [6:0]  w_cnt_d, w_cnt_a, w_cnt_p;
  logic [5:0]  w_width, w_lshift;
  logic [31:0] w_field;
  logic [2:0]  w_pad;
  logic [7:0]  w_pad_byte, w_byte, w_code;

  assign w_ready      = (r_state == S_DATA) && (r_cnt <= 7'd32);
  assign w_slot       = !r_dout_en || DataOutRead;
  assign w_drain_ok   = ((r_state == S_DATA) || (r_state == S_FLUSH)) && w_slot;
  assign w_emit_stuff = w_drain_ok && r_stuff;
  assign w_emit_data  = w_drain_ok && !r_stuff && (r_cnt >= 7'd8);

  // Drain happens on the registered buffer first, so new fields land behind the departing byte.
  assign w_buf_d = w_emit_data ? (r_buf << 8) : r_buf;
  assign w_cnt_d = w_emit_data ? (r_cnt - 7'd8) : r_cnt;

  assign w_accept   = DataInEnable && w_ready;
  assign w_width    = (DataInWidth > 6'd32) ? 6'd32 : DataInWidth;
  assign w_lshift   = 6'd32 - w_width;
  assign w_field    = DataIn & (32'hFFFF_FFFF >> w_lshift);
  assign w_field_la = {w_field, 32'd0} << w_lshift;
  assign w_buf_a    = w_accept ? (w_buf_d | (w_field_la >> w_cnt_d)) : w_buf_d;
  assign w_cnt_a    = w_accept ? (w_cnt_d + {1'b0, w_width}) : w_cnt_d;

  // Every command pads to a byte boundary, computed after any same-cycle field append.
  assign w_cmd      = w_ready && (DataInFinish || DataInRestart || DataInAlign);
  assign w_pad      = 3'd0 - w_cnt_a[2:0];
  assign w_pad_byte = ~(8'hFF >> w_pad);
  assign w_buf_p    = w_cmd ? (w_buf_a | ({w_pad_byte, 56'd0} >> w_cnt_a)) : w_buf_a;
  assign w_cnt_p    = w_cmd ? (w_cnt_a + {4'd0, w_pad}) : w_cnt_a;

`ifdef AQ_CJPEG_RESTART_EN
  logic w_rst_cmd;
  assign w_rst_cmd = w_ready && !DataInFinish && DataInRestart;
  assign w_code    = r_eoi ? 8'hD9 : {5'b11010, r_rst_idx};
`else
  assign w_code    = 8'hD9;
`endif

  always_comb begin
    w_emit = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      S_DATA, S_FLUSH: begin
        if (w_emit_stuff) begin
          w_emit = 1'b1;
        end else if (w_emit_data) begin
          w_emit = 1'b1;
          w_byte = r_buf[63:56];
        end
      end
      S_MARK_FF: begin
        w_emit = w_slot;
        w_byte = 8'hFF;
      end
      default: begin
        w_emit = w_slot;
        w_byte = w_code;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_DATA;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_stuff   <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
`ifdef AQ_CJPEG_RESTART_EN
      r_eoi     <= 1'b0;
      r_rst_idx <= '0;
`endif
    end else if (ProcessInit) begin
      r_state   <= S_DATA;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_stuff   <= 1'b0;
      r_dout    <= '0;
      r_dout_en <= 1'b0;
`ifdef AQ_CJPEG_RESTART_EN
      r_eoi     <= 1'b0;
      r_rst_idx <= '0;
`endif
    end else begin
      r_buf <= w_buf_p;
      r_cnt <= w_cnt_p;
      if (w_emit) begin
        r_dout    <= w_byte;
        r_dout_en <= 1'b1;
      end else if (DataOutRead) begin
        r_dout_en <= 1'b0;
      end
      // Only data bytes arm stuffing; marker bytes go out through the marker states.
      if (w_emit_stuff) begin
        r_stuff <= 1'b0;
      end else if (w_emit_data && (r_buf[63:56] == 8'hFF)) begin
        r_stuff <= 1'b1;
      end
      case (r_state)
        S_DATA: begin
          if (w_ready && DataInFinish) begin
            r_state <= S_FLUSH;
`ifdef AQ_CJPEG_RESTART_EN
            r_eoi   <= 1'b1;
          end else if (w_rst_cmd) begin
            r_state <= S_FLUSH;
            r_eoi   <= 1'b0;
`endif
          end
        end
        S_FLUSH: begin
          if ((r_cnt == 7'd0) && !r_stuff) r_state <= S_MARK_FF;
        end
        S_MARK_FF: begin
          if (w_slot) r_state <= S_MARK_CODE;
        end
        default: begin
          if (w_slot) begin
            r_state <= S_DATA;
`ifdef AQ_CJPEG_RESTART_EN
            if (!r_eoi) r_rst_idx <= r_rst_idx + 3'd1;
`endif
          end
        end
      endcase
    end
  end

  assign DataInReady   = w_ready;
  assign DataOutEnable = r_dout_en;
  assign DataOut       = r_dout;
  assign Idle          = (r_state == S_DATA) && (r_cnt == 7'd0) && !r_dout_en && !r_stuff;

endmodule

// File: tb/tb_aq_cjpeg_bitpack.sv
// tb/tb_aq_cjpeg_bitpack.sv - self-checking bench for aq_cjpeg_bitpack (table vectors + byte scoreboard)
module tb_aq_cjpeg_bitpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ProcessInit = 1'b0;
  logic        DataInEnable = 1'b0;
  logic [5:0]  DataInWidth = '0;
  logic [31:0] DataIn = '0;
  logic        DataInAlign = 1'b0;
  logic        DataInRestart = 1'b0;
  logic        DataInFinish = 1'b0;
  logic        DataInReady;
  logic        DataOutEnable;
  logic        DataOutRead = 1'b0;
  logic [7:0]  DataOut;
  logic        Idle;

  aq_cjpeg_bitpack dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit),
    .DataInEnable(DataInEnable), .DataInWidth(DataInWidth), .DataIn(DataIn),
    .DataInAlign(DataInAlign), .DataInRestart(DataInRestart), .DataInFinish(DataInFinish),
    .DataInReady(DataInReady), .DataOutEnable(DataOutEnable), .DataOutRead(DataOutRead),
    .DataOut(DataOut), .Idle(Idle)
  );

  always #5 clk = ~clk;

  // cmd = {finish, restart, align}; exp holds n bytes MSB-first
  typedef struct {
    logic [5:0]  w;
    logic [31:0] d;
    logic [2:0]  cmd;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] sb[$];
  int         tests = 0;
  int         fails = 0;
  bit         consume_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_bytes(input int n, input logic [31:0] e);
    logic [31:0] t;
    t = e;
    for (int i = 0; i < n; i++) begin
      sb.push_back(t[31:24]);
      t = t << 8;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_b;
    DataOutRead = consume_en && ($urandom_range(0, 3) != 0);
    if (DataOutRead && DataOutEnable) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got %0h expected none", DataOut);
      end else begin
        exp_b = sb.pop_front();
        chk("byte", {24'd0, DataOut}, {24'd0, exp_b});
      end
    end
  end

  task automatic send(input logic [5:0] w, input logic [31:0] d, input logic [2:0] cmd);
    int t = 0;
    while (!DataInReady && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!DataInReady) begin
      tests++;
      fails++;
      $display("FAIL send_ready_timeout: got 0 expected 1");
    end
    DataInEnable  = (w != 6'd0);
    DataInWidth   = w;
    DataIn        = d;
    DataInAlign   = cmd[0];
    DataInRestart = cmd[1];
    DataInFinish  = cmd[2];
    @(negedge clk);
    DataInEnable  = 1'b0;
    DataInWidth   = '0;
    DataIn        = '0;
    DataInAlign   = 1'b0;
    DataInRestart = 1'b0;
    DataInFinish  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (!(sb.size() == 0 && Idle) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, {31'd0, (sb.size() == 0 && Idle)}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_drop;
    int words;
    vecs[0]  = '{6'd8,  32'h0000_00A5, 3'b000, 1, 32'hA500_0000};
    vecs[1]  = '{6'd0,  32'h0,         3'b100, 2, 32'hFFD9_0000};
    vecs[2]  = '{6'd8,  32'h0000_00FF, 3'b000, 2, 32'hFF00_0000};
    vecs[3]  = '{6'd4,  32'h0000_0003, 3'b000, 0, 32'h0};
    vecs[4]  = '{6'd0,  32'h0,         3'b100, 3, 32'h3FFF_D900};
    vecs[5]  = '{6'd1,  32'h0000_0001, 3'b000, 0, 32'h0};
    vecs[6]  = '{6'd0,  32'h0,         3'b001, 2, 32'hFF00_0000};
    vecs[7]  = '{6'd8,  32'h0000_0000, 3'b000, 1, 32'h0000_0000};
    vecs[8]  = '{6'd0,  32'h0,         3'b001, 0, 32'h0};
    vecs[9]  = '{6'd33, 32'h1234_5678, 3'b000, 4, 32'h1234_5678};
    vecs[10] = '{6'd4,  32'hFFFF_FF05, 3'b000, 0, 32'h0};
    vecs[11] = '{6'd4,  32'h0000_000A, 3'b000, 1, 32'h5A00_0000};
    vecs[12] = '{6'd1,  32'h0000_0001, 3'b001, 2, 32'hFF00_0000};
    vecs[13] = '{6'd3,  32'h0000_0000, 3'b100, 3, 32'h1FFF_D900};

    repeat (3) @(negedge clk);
    chk("reset_out_en", {31'd0, DataOutEnable}, 32'd0);
    chk("reset_dout", {24'd0, DataOut}, 32'd0);
    chk("reset_idle", {31'd0, Idle}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, DataInReady}, 32'd1);
    chk("reset_idle_run", {31'd0, Idle}, 32'd1);

    consume_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push_bytes(vecs[i].n, vecs[i].exp);
      send(vecs[i].w, vecs[i].d, vecs[i].cmd);
    end
    wait_drain("table_drain_idle");

    // Backpressure: hold the consumer off while streaming 32-bit words.
    consume_en = 1'b0;
    saw_drop = 1'b0;
    words = 0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (DataInReady) begin
        push_bytes(4, 32'h1234_5678);
        words++;
        DataInEnable = 1'b1;
        DataInWidth  = 6'd32;
        DataIn       = 32'h1234_5678;
      end else begin
        saw_drop = 1'b1;
        DataInEnable = 1'b0;
      end
      @(negedge clk);
      DataInEnable = 1'b0;
    end
    chk("bp_ready_dropped", {31'd0, saw_drop}, 32'd1);
    chk("bp_words_accepted", words, 32'd2);
    chk("bp_out_held_en", {31'd0, DataOutEnable}, 32'd1);
    chk("bp_out_held_byte", {24'd0, DataOut}, 32'h12);
    consume_en = 1'b1;
    push_bytes(2, 32'hFFD9_0000);
    send(6'd0, 32'd0, 3'b100);
    wait_drain("bp_drain_idle");

    // Restart markers on an aligned (empty) stream.
`ifdef AQ_CJPEG_RESTART_EN
    for (int i = 0; i < 9; i++) begin
      push_bytes(2, {8'hFF, 8'hD0 | 8'(i % 8), 16'd0});
      send(6'd0, 32'd0, 3'b010);
    end
`else
    for (int i = 0; i < 9; i++) send(6'd0, 32'd0, 3'b010);
`endif
    push_bytes(1, 32'h5A00_0000);
    send(6'd8, 32'h5A, 3'b000);
    wait_drain("restart_drain_idle");

    // ProcessInit with 20 bits buffered and a byte held on the output.
    consume_en = 1'b0;
    @(negedge clk);
    send(6'd20, 32'h000A_BCDE, 3'b000);
    repeat (3) @(negedge clk);
    chk("init_pre_out_en", {31'd0, DataOutEnable}, 32'd1);
    chk("init_pre_idle", {31'd0, Idle}, 32'd0);
    ProcessInit  = 1'b1;
    DataInEnable = 1'b1;
    DataInWidth  = 6'd8;
    DataIn       = 32'hFF;
    DataInFinish = 1'b1;
    @(negedge clk);
    ProcessInit  = 1'b0;
    DataInEnable = 1'b0;
    DataInWidth  = '0;
    DataIn       = '0;
    DataInFinish = 1'b0;
    chk("init_out_en", {31'd0, DataOutEnable}, 32'd0);
    chk("init_idle", {31'd0, Idle}, 32'd1);
    chk("init_ready", {31'd0, DataInReady}, 32'd1);
    consume_en = 1'b1;
    push_bytes(3, 32'hC3FF_D900);
    send(6'd8, 32'hC3, 3'b000);
    send(6'd0, 32'd0, 3'b100);
    wait_drain("init_drain_idle");
    repeat (5) @(negedge clk);
    chk("final_idle", {31'd0, Idle}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
